// File: rtl/fetch_stage.sv
// fetch_stage: instruction-fetch stage of the five-stage MIPS pipeline.
// Owns the PC, drives the SRAM-like instruction request bus and presents
// one fetch slot (PC plus status) to decode. Redirects from execute
// (taken branch/jump) and commit (exception/ERET) follow delay-slot rules.
// Wrong-path fetches always complete on the bus and are flagged cancelled.
//
// Optional feature: define FETCH_ADEL_EN to raise an AdEL fetch exception
// for misaligned PCs and halt fetching until the next exception redirect.
// Without it the address is forced word-aligned and no exception is raised.
`timescale 1ns/1ps

module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'hbfc00000
) (
    input  logic        clk,
    input  logic        resetn,
    output logic        inst_req,
    output logic [31:0] inst_addr,
    input  logic        inst_addr_ok,
    input  logic        br_taken_i,
    input  logic [31:0] br_target_i,
    input  logic        exc_redirect_i,
    input  logic [31:0] exc_target_i,
    input  logic        ready_i,
    output logic        valid_o,
    output logic [31:0] pc_o,
    output logic        cancelled_o,
    output logic        exc_o,
    output logic        exc_miss_o,
    output logic [4:0]  exccode_o
);

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_HOLD = 2'd1,
        ST_HALT = 2'd2
    } state_t;

    localparam logic [4:0] EXC_ADEL = 5'h04;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        valid_q, valid_d;
    logic [31:0] pc_out_q, pc_out_d;
    logic        cancelled_q, cancelled_d;
    logic        exc_q, exc_d;
    logic [4:0]  exccode_q, exccode_d;
    logic        kill_q, kill_d;
    logic        br_pend_q, br_pend_d;
    logic [31:0] redir_q, redir_d;

    logic slot_free;
    logic slot_live;
    logic misaligned;
    logic adel_fault;
    logic accept;
    logic stall;
    logic br_use;
    logic wrong_path;

`ifdef FETCH_ADEL_EN
    assign misaligned = (pc_q[1:0] != 2'b00);
`else
    assign misaligned = 1'b0;
`endif

    // Slot can take a new fetch when empty or being consumed this cycle.
    assign slot_free  = !valid_q || ready_i;
    // A live slot is a real (non-wrong-path) instruction: a branch now in
    // execute means this slot is its delay slot.
    assign slot_live  = valid_q && !cancelled_q;
    // Misaligned fetch in RUN turns into an exception slot instead of a request.
    assign adel_fault = resetn && (state_q == ST_RUN) && slot_free && misaligned;
    assign accept     = inst_req && inst_addr_ok;
    // An issued request that was not taken must stay on the bus unchanged,
    // so redirects in that cycle are deferred through kill/redir.
    assign stall      = inst_req && !inst_addr_ok;
    assign br_use     = br_taken_i && !exc_redirect_i;
    // Anything entering the slot this cycle is wrong-path in these cases.
    assign wrong_path = kill_q || exc_redirect_i || (br_use && slot_live);

    // State register.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: HOLD keeps an unaccepted request alive, HALT parks after AdEL.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN: begin
                if (adel_fault && !wrong_path) begin
                    state_d = ST_HALT;
                end else if (stall) begin
                    state_d = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (inst_addr_ok) begin
                    state_d = ST_RUN;
                end
            end
            ST_HALT: begin
                if (exc_redirect_i) begin
                    state_d = ST_RUN;
                end
            end
            default: state_d = ST_RUN;
        endcase
    end

    // Output logic: request is suppressed during reset and while halted.
    always_comb begin
        inst_req = 1'b0;
        if (resetn) begin
            case (state_q)
                ST_HOLD: inst_req = 1'b1;
                ST_RUN:  inst_req = slot_free && !misaligned;
                default: inst_req = 1'b0;
            endcase
        end
`ifdef FETCH_ADEL_EN
        inst_addr = pc_q;
`else
        inst_addr = {pc_q[31:2], 2'b00};
`endif
    end

    // Datapath next-state: slot contents, PC sequencing and redirect bookkeeping.
    always_comb begin
        pc_d        = pc_q;
        valid_d     = valid_q;
        pc_out_d    = pc_out_q;
        cancelled_d = cancelled_q;
        exc_d       = exc_q;
        exccode_d   = exccode_q;
        kill_d      = kill_q;
        br_pend_d   = br_pend_q;
        redir_d     = redir_q;

        // Slot update: a new fetch, an AdEL exception, a consume, or a flush.
        if (accept) begin
            valid_d     = 1'b1;
            pc_out_d    = pc_q;
            cancelled_d = wrong_path;
            exc_d       = 1'b0;
            exccode_d   = 5'h00;
        end else if (adel_fault) begin
            valid_d     = 1'b1;
            pc_out_d    = pc_q;
            cancelled_d = wrong_path;
            exc_d       = 1'b1;
            exccode_d   = EXC_ADEL;
        end else if (ready_i) begin
            valid_d     = 1'b0;
            cancelled_d = 1'b0;
        end else if (exc_redirect_i && valid_q) begin
            cancelled_d = 1'b1;
        end

        // Sequential PC advance, or a deferred redirect once the held fetch goes.
        if (accept) begin
            if (kill_q || br_pend_q) begin
                pc_d      = redir_q;
                kill_d    = 1'b0;
                br_pend_d = 1'b0;
            end else begin
                pc_d = pc_q + 32'd4;
            end
        end

        // Redirects: exception wins over branch.
        if (exc_redirect_i) begin
            br_pend_d = 1'b0;
            if (stall) begin
                kill_d  = 1'b1;
                redir_d = exc_target_i;
            end else begin
                pc_d   = exc_target_i;
                kill_d = 1'b0;
            end
        end else if (br_use) begin
            if (slot_live) begin
                // Delay slot already fetched: the in-flight request is wrong-path.
                if (stall) begin
                    kill_d  = 1'b1;
                    redir_d = br_target_i;
                end else begin
                    pc_d = br_target_i;
                end
            end else if (accept) begin
                // The fetch accepted right now is the delay slot.
                pc_d = br_target_i;
            end else begin
                // Delay slot still to be accepted; redirect after it.
                br_pend_d = 1'b1;
                redir_d   = br_target_i;
            end
        end
    end

    // Datapath registers.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            pc_q        <= RESET_PC;
            valid_q     <= 1'b0;
            pc_out_q    <= 32'h0;
            cancelled_q <= 1'b0;
            exc_q       <= 1'b0;
            exccode_q   <= 5'h00;
            kill_q      <= 1'b0;
            br_pend_q   <= 1'b0;
            redir_q     <= 32'h0;
        end else begin
            pc_q        <= pc_d;
            valid_q     <= valid_d;
            pc_out_q    <= pc_out_d;
            cancelled_q <= cancelled_d;
            exc_q       <= exc_d;
            exccode_q   <= exccode_d;
            kill_q      <= kill_d;
            br_pend_q   <= br_pend_d;
            redir_q     <= redir_d;
        end
    end

    assign valid_o     = valid_q;
    assign pc_o        = pc_out_q;
    assign cancelled_o = cancelled_q;
    assign exc_o       = exc_q;
    assign exccode_o   = exccode_q;
    assign exc_miss_o  = 1'b0;

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage of the five-stage MIPS pipeline. It owns the PC, issues requests on the SRAM-like instruction bus, and hands each accepted fetch (PC plus status) to the decode stage, which later consumes the matching `inst_data_ok`/`inst_rdata` beat itself. Redirects are applied with MIPS delay-slot semantics:

- a taken branch/jump from execute;
- an exception/ERET from commit.

Wrong-path fetches are marked cancelled, never dropped from the bus.

## Interface
- `RESET_PC`, default `32'hbfc00000`, first PC fetched after reset.

Ports:
- `clk`  in  1  clock.
- `resetn`  in  1  reset, synchronous, active-low.
- `inst_req`  out  1  fetch request.
- `inst_addr`  out  32  fetch address, stable while `inst_req` is held.
- `inst_addr_ok`  in  1  request accepted this cycle.
- `br_taken_i`  in  1  one-cycle pulse: a taken branch/jump leaves execute.
- `br_target_i`  in  32  branch target, valid with `br_taken_i`.
- `exc_redirect_i`  in  1  one-cycle pulse: exception/ERET flush.
- `exc_target_i`  in  32  handler/EPC address, valid with `exc_redirect_i`.
- `ready_i`  in  1  decode takes the current slot this cycle.
- `valid_o`  out  1  slot holds a fetch.
- `pc_o`  out  32  PC of slot.
- `cancelled_o`  out  1  slot is wrong-path; decode waits for its data and discards it.
- `exc_o`  out  1  fetch exception.
- `exc_miss_o`  out  1  TLB refill; constant 0, reserved.
- `exccode_o`  out  5  exception code.

## Operation
- Registers:
  - `pc`;
  - output slot (`valid_o`, `pc_o`, `cancelled_o`, `exc_o`, `exccode_o`);
  - `state` ∈ {RUN, HOLD, HALT};
  - `kill` (held request is wrong-path);
  - `br_pend` (next accepted fetch is the delay slot);
  - `redir_pc` (32-bit).
- `slot_free` = `!valid_o || ready_i`.
- `inst_req` = (`state`==HOLD) || (`state`==RUN && `slot_free`).
- `inst_addr` = `pc`.
- Transitions:
  - RUN: if `inst_req` && !`inst_addr_ok` → HOLD. In HOLD, `inst_req` stays high and `pc` is frozen until `inst_addr_ok`.
  - Acceptance (`inst_req` && `inst_addr_ok`, from RUN or HOLD): the slot loads `valid_o`=1, `pc_o`=`pc`, `cancelled_o`=`kill`, `exc_o`=0, and the state returns to RUN.
  - Next `pc` on acceptance: `redir_pc` if `kill` or `br_pend` (then both clear); otherwise `pc`+4.
  - Slot consumed (`ready_i`) with no acceptance: `valid_o`←0, `cancelled_o`←0.
- `br_taken_i` (ignored if `exc_redirect_i` is in the same cycle):
  - Slot valid and not cancelled: the slot is the delay slot.
    - In HOLD: `kill`←1, `redir_pc`←target.
    - In RUN: `pc`←target directly; a same-cycle acceptance still loads the slot with the old `pc`, marked cancelled.
  - Slot empty: the delay slot is not yet issued.
    - `br_pend`←1, `redir_pc`←target.
    - The held or next request is the delay slot and is passed uncancelled; the fetch after it uses the target.
- `exc_redirect_i` has highest priority:
  - Slot, if still present next cycle, gets `cancelled_o`←1.
  - Any fetch accepted in the same cycle is loaded cancelled.
  - In HOLD: `kill`←1, `redir_pc`←target. Otherwise `pc`←target.
  - `br_pend`←0. HALT → RUN.
- Arithmetic: `pc`+4 is modulo 2^32 (0xFFFFFFFC wraps to 0).

## Timing
- Reset: `valid_o`=0, `pc_o`=0, `cancelled_o`=0, `exc_o`=0, `exc_miss_o`=0, `exccode_o`=0, `pc`=`RESET_PC`, state RUN, flags 0.
- `inst_req`=0 during the reset cycle; it is first high in the cycle after `resetn` rises.
- Latency:
  - Acceptance at edge N gives `valid_o`=1 after edge N.
  - Back-to-back fetches at one per cycle while `ready_i`=1 and `inst_addr_ok`=1.
- Redirects take effect on `inst_addr` in the cycle after the pulse.
- In HOLD, they take effect in the cycle after the held request is accepted.
- A request is never withdrawn and its address never changes while it is unaccepted.

## Configuration
- `FETCH_ADEL_EN` defined:
  - In RUN with `slot_free` and `pc[1:0]`≠0: no request is issued.
  - Slot loads `valid_o`=1, `exc_o`=1, `exccode_o`=5'h04 (AdEL), `pc_o`=`pc`.
  - State → HALT (no requests) until `exc_redirect_i`.
  - A pending `br_pend` redirect to a misaligned target produces this on that fetch.
- Undefined: no check; `inst_addr`=`{pc[31:2],2'b00}`, `exc_o` constant 0, HALT unreachable.

## Test plan
- Reset, `inst_addr_ok`=1, `ready_i`=1 → `inst_addr` 0xbfc00000, 0xbfc00004, 0xbfc00008 on consecutive cycles; `valid_o`=1 from cycle 2.
- `inst_addr_ok` low 3 cycles with `br_taken_i` (target 0x80001000) and a valid slot in cycle 1 → `inst_addr` held, accepted fetch has `cancelled_o`=1, next `inst_addr`=0x80001000.
- `br_taken_i` with slot empty, `pc`=0xbfc00010 → 0xbfc00010 fetched uncancelled, next `inst_addr`=target.
- `exc_redirect_i` (target 0xbfc00380) with valid slot and `ready_i`=0 → `cancelled_o`=1 next cycle, next `inst_addr`=0xbfc00380, `br_pend` cleared.
- `FETCH_ADEL_EN`, branch to 0x80000002 → slot `exc_o`=1, `exccode_o`=4, `inst_req`=0 until `exc_redirect_i`.
- `pc`=0xfffffffc accepted → next `inst_addr`=0x00000000.
